// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main-control FSM for the multi-cycle RV32I core
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_sel,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic             retire,
  output logic [CNT_W-1:0] instret_count,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] WAIT_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t      state;
  logic [31:0] wait_cnt;
  logic        handshake;
  logic        timeout_hit;
  logic        legal;
  logic [2:0]  imm_dec;

  assign handshake   = mem_req & mem_ready;
  // a handshake on the last allowed cycle wins over the timeout
  assign timeout_hit = (TIMEOUT > 0) && mem_req && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    legal   = 1'b1;
    imm_dec = 3'b000;
    case (op)
      OP_R:                     imm_dec = 3'b000;
      OP_I, OP_LOAD, OP_JALR:   imm_dec = 3'b001;
      OP_STORE:                 imm_dec = 3'b010;
      OP_BRANCH:                imm_dec = 3'b011;
      OP_LUI, OP_AUIPC:         imm_dec = 3'b100;
      OP_JAL:                   imm_dec = 3'b101;
      default:                  legal   = 1'b0;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_sel    = 3'b000;
    reg_write  = 1'b0;
    result_src = 2'b00;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: imm_sel = imm_dec;
      S_EXEC: begin
        imm_sel = imm_dec;
        case (op)
          OP_R:             alu_op = 2'b10;
          OP_I: begin
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
          end
          OP_LOAD, OP_STORE: alu_src_b = 2'b01;
          OP_BRANCH: begin
            alu_op   = 2'b01;
            pc_src   = 2'b10;
            pc_write = branch_taken;
            retire   = 1'b1;
          end
          OP_JAL: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end
          OP_JALR: begin
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
            pc_src    = 2'b01;
          end
          OP_LUI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
          end
          OP_AUIPC: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        imm_sel   = imm_dec;
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_we    = (op == OP_STORE);
        mdr_write = mem_ready & (op == OP_LOAD);
        retire    = mem_ready & (op == OP_STORE);
      end
      S_WB: begin
        imm_sel   = imm_dec;
        reg_write = 1'b1;
        retire    = 1'b1;
        if (op == OP_LOAD)                       result_src = 2'b01;
        else if (op == OP_JAL || op == OP_JALR)  result_src = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      wait_cnt      <= 32'd0;
      instret_count <= '0;
      trap          <= 1'b0;
      trap_cause    <= 2'b00;
    end else begin
      if (retire) instret_count <= instret_count + CNT_W'(1);
      // entering FETCH/MEM always comes from a non-requesting state or a handshake
      if (handshake || !mem_req) wait_cnt <= 32'd0;
      else                       wait_cnt <= wait_cnt + 32'd1;
      case (state)
        S_FETCH, S_MEM: begin
          if (handshake) begin
            if (state == S_FETCH)       state <= S_DECODE;
            else if (op == OP_STORE)    state <= S_FETCH;
            else                        state <= S_WB;
          end else if (timeout_hit) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end
        end
        S_DECODE: begin
          if (legal) state <= S_EXEC;
          else begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b01;
          end
        end
        S_EXEC: begin
          if (op == OP_LOAD || op == OP_STORE) state <= S_MEM;
          else if (op == OP_BRANCH)            state <= S_FETCH;
          else                                 state <= S_WB;
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam int N_RAND = 40;

  logic clk = 1'b0;
  logic rst, branch_taken, mem_ready;
  logic [6:0] op;
  logic mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, reg_write, retire, trap;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
  logic [2:0] imm_sel;
  logic [3:0] instret_count;

  multicycle_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .op(op), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .reg_write(reg_write),
    .result_src(result_src), .retire(retire), .instret_count(instret_count),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct { logic [6:0] op; logic bt; int fw; int mw; } instr_t;
  typedef struct {
    int fw; int mw; int lat; bit is_load; bit is_mem;
    logic [1:0] a; logic [1:0] b; logic [1:0] aop; logic [1:0] psrc; logic pw_exec; logic [2:0] imm;
    logic rw; logic [1:0] rs; logic we; logic pw_ret; logic [3:0] cnt;
  } exp_t;

  instr_t prog[$];
  exp_t   sb[$];
  int tests = 0, fails = 0, pushed = 0, retired_n = 0;
  bit auto_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected behaviour of one instruction, straight from the per-opcode rules
  function automatic exp_t model(instr_t d, int idx);
    exp_t e;
    e.fw = d.fw; e.mw = d.mw;
    e.is_load = (d.op == OP_LOAD);
    e.is_mem  = (d.op == OP_LOAD) || (d.op == OP_STORE);
    e.a = 2'b00; e.b = 2'b00; e.aop = 2'b00; e.psrc = 2'b00; e.pw_exec = 1'b0;
    e.rw = 1'b1; e.rs = 2'b00; e.we = 1'b0; e.pw_ret = 1'b0; e.imm = 3'b000;
    e.cnt = 4'(idx);
    e.lat = 4;
    case (d.op)
      OP_R:      e.aop = 2'b10;
      OP_I:      begin e.b = 2'b01; e.aop = 2'b10; e.imm = 3'b001; end
      OP_LOAD:   begin e.b = 2'b01; e.imm = 3'b001; e.rs = 2'b01; e.lat = 5; end
      OP_STORE:  begin e.b = 2'b01; e.imm = 3'b010; e.rw = 1'b0; e.we = 1'b1; end
      OP_BRANCH: begin e.aop = 2'b01; e.psrc = 2'b10; e.pw_exec = d.bt; e.imm = 3'b011;
                       e.rw = 1'b0; e.pw_ret = d.bt; e.lat = 3; end
      OP_JAL:    begin e.pw_exec = 1'b1; e.psrc = 2'b10; e.imm = 3'b101; e.rs = 2'b10; end
      OP_JALR:   begin e.b = 2'b01; e.pw_exec = 1'b1; e.psrc = 2'b01; e.imm = 3'b001; e.rs = 2'b10; end
      OP_LUI:    begin e.a = 2'b10; e.b = 2'b01; e.imm = 3'b100; end
      default:   begin e.a = 2'b01; e.b = 2'b01; e.imm = 3'b100; end
    endcase
    e.lat = e.lat + d.fw + (e.is_mem ? d.mw : 0);
    return e;
  endfunction

  // memory responder: feeds instructions and wait states, pushes expectations
  initial begin : responder
    instr_t d;
    int fwl = 0, mwl = 0;
    bit armed = 0;
    forever begin
      @(posedge clk); #2;
      if (!auto_run) armed = 0;
      else if (!mem_req) mem_ready = 1'($urandom_range(0, 1));
      else begin
        if (!addr_sel && !armed && prog.size() > 0) begin
          d = prog.pop_front();
          op = d.op; branch_taken = d.bt; fwl = d.fw; mwl = d.mw; armed = 1;
          sb.push_back(model(d, pushed));
          pushed++;
        end
        if (!addr_sel && !armed) mem_ready = 1'b0;
        else if (!addr_sel) begin
          if (fwl > 0) begin mem_ready = 1'b0; fwl--; end
          else begin mem_ready = 1'b1; armed = 0; end
        end else begin
          if (mwl > 0) begin mem_ready = 1'b0; mwl--; end
          else mem_ready = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    int lat = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!auto_run) lat = 0;
      else begin
        lat++;
        chk("no_trap", 32'(trap), 32'd0);
        if (sb.size() > 0) begin
          e = sb[0];
          chk("mem_req", 32'(mem_req), 32'((lat <= e.fw + 1) ||
              (e.is_mem && lat >= e.fw + 4 && lat <= e.fw + 4 + e.mw)));
          chk("ir_write", 32'(ir_write), 32'(lat == e.fw + 1));
          chk("mdr_write", 32'(mdr_write), 32'(e.is_load && lat == e.fw + 4 + e.mw));
          if (lat == e.fw + 3) begin
            chk("exec_a", 32'(alu_src_a), 32'(e.a));
            chk("exec_b", 32'(alu_src_b), 32'(e.b));
            chk("exec_aluop", 32'(alu_op), 32'(e.aop));
            chk("exec_pcsrc", 32'(pc_src), 32'(e.psrc));
            chk("exec_pcwrite", 32'(pc_write), 32'(e.pw_exec));
            chk("exec_imm", 32'(imm_sel), 32'(e.imm));
          end
        end
        if (retire) begin
          if (sb.size() == 0) chk("unexpected_retire", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("latency", 32'(lat), 32'(e.lat));
            chk("ret_reg_write", 32'(reg_write), 32'(e.rw));
            chk("ret_result_src", 32'(result_src), 32'(e.rs));
            chk("ret_mem_we", 32'(mem_we), 32'(e.we));
            chk("ret_pc_write", 32'(pc_write), 32'(e.pw_ret));
            chk("instret", 32'(instret_count), 32'(e.cnt));
            retired_n++;
          end
          lat = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1; mem_ready = 1'b0; auto_run = 0;
    tick(); rst = 1'b0;
  endtask

  initial begin : main
    logic [6:0] ops[9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    instr_t d;
    rst = 1'b1; op = OP_I; branch_taken = 1'b0; mem_ready = 1'b0;
    do_reset();

    // reset state, then ADDI with one fetch wait, then a store abandoned by reset
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd1);
    chk("rst_strobes", 32'({ir_write, pc_write, reg_write, mem_we, mdr_write, retire}), 32'd0);
    chk("rst_trap", 32'({trap, trap_cause}), 32'd0);
    chk("rst_instret", 32'(instret_count), 32'd0);
    chk("rst_imm", 32'(imm_sel), 32'd0);
    tick(); mem_ready = 1'b1;
    @(negedge clk); chk("addi_ir_write", 32'(ir_write), 32'd1);
    tick(); @(negedge clk);
    chk("addi_decode_req", 32'(mem_req), 32'd0);
    chk("addi_decode_imm", 32'(imm_sel), 32'b001);
    tick(); @(negedge clk);
    chk("addi_exec", 32'({alu_src_a, alu_src_b, alu_op}), 32'b00_01_10);
    tick(); @(negedge clk);
    chk("addi_wb", 32'({reg_write, result_src, retire}), 32'b1_00_1);
    tick(); op = OP_STORE;
    @(negedge clk);
    chk("addi_count", 32'(instret_count), 32'd1);
    tick(); tick(); @(negedge clk);
    chk("st_exec", 32'({alu_src_a, alu_src_b, alu_op}), 32'b00_01_00);
    tick(); mem_ready = 1'b0;
    @(negedge clk);
    chk("st_mem", 32'({mem_req, mem_we, addr_sel, retire}), 32'b1110);
    tick(); rst = 1'b1;
    @(negedge clk); chk("st_wait_no_retire", 32'(retire), 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("st_rst_fetch", 32'({mem_req, mem_we, addr_sel}), 32'b100);
    chk("st_rst_count", 32'(instret_count), 32'd0);

    // illegal opcode
    do_reset(); op = 7'b1111111; mem_ready = 1'b1;
    @(negedge clk); chk("ill_fetch", 32'(ir_write), 32'd1);
    tick(); @(negedge clk);
    chk("ill_decode", 32'({mem_req, ir_write, pc_write, reg_write, trap}), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick(); @(negedge clk);
      chk("ill_trap", 32'({trap, trap_cause, mem_req}), 32'b1_01_0);
      chk("ill_count", 32'(instret_count), 32'd0);
    end

    // fetch timeout, then handshake on the last allowed cycle
    do_reset(); op = OP_I;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("tmo_wait", 32'({trap, mem_req}), 32'b01);
      tick();
    end
    @(negedge clk); chk("tmo_trap", 32'({trap, trap_cause, mem_req}), 32'b1_10_0);
    do_reset(); op = OP_I;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("tmo_edge_wait", 32'({trap, mem_req}), 32'b01);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk); chk("tmo_edge_hs", 32'({trap, ir_write}), 32'b01);
    tick(); mem_ready = 1'b0;
    @(negedge clk); chk("tmo_edge_decode", 32'({trap, mem_req, imm_sel}), 32'b0_0_001);

    // randomized program against the scoreboard
    for (int i = 0; i < N_RAND; i++) begin
      d.op = ops[$urandom_range(0, 8)];
      d.bt = 1'($urandom_range(0, 1));
      d.fw = $urandom_range(0, 3);
      d.mw = $urandom_range(0, 3);
      prog.push_back(d);
    end
    pushed = 0; retired_n = 0;
    do_reset(); auto_run = 1;
    for (int c = 0; c < 2000 && retired_n < N_RAND; c++) @(negedge clk);
    chk("rand_retired", 32'(retired_n), 32'(N_RAND));
    @(negedge clk);
    chk("rand_wrap_count", 32'(instret_count), 32'(N_RAND % 16));
    auto_run = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main-control FSM for the multi-cycle RV32I core variant.
- Sequences the shared datapath (one ALU, one unified memory port, register file) through FETCH/DECODE/EXEC/MEM/WB.
- Handles the memory req/ready handshake, flags illegal opcodes and memory timeouts, and counts retired instructions.
- Signal encodings (ALUOp, ResultSrc, imm_sel) match the core's single-cycle control decode.

Parameters:
CNT_W, 32, width of instret_count (wraps modulo 2^CNT_W)
TIMEOUT, 0, max cycles to wait for mem_ready per transfer; 0 = wait forever

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
op  input  7  opcode from IR; valid from DECODE until the next FETCH handshake
branch_taken  input  1  comparator result for the current branch (valid in EXEC)
mem_ready  input  1  memory accepts/completes the current request
mem_req  output  1  memory request
mem_we  output  1  memory write enable
addr_sel  output  1  memory address mux: 0 = PC, 1 = ALUOut
ir_write  output  1  latch IR and OldPC
mdr_write  output  1  latch load data
pc_write  output  1  PC update
pc_src  output  2  PC mux: 00 = PC+4, 01 = ALU result, 10 = OldPC+imm target adder
alu_src_a  output  2  ALU A mux: 00 = rs1, 01 = OldPC, 10 = zero
alu_src_b  output  2  ALU B mux: 00 = rs2, 01 = imm, 10 = const 4
alu_op  output  2  00 = add, 01 = branch compare, 10 = funct-decoded
imm_sel  output  3  000 = none, 001 = I, 010 = S, 011 = B, 100 = U, 101 = J
reg_write  output  1  register-file write
result_src  output  2  WB mux: 00 = ALUOut, 01 = MDR, 10 = OldPC+4
retire  output  1  one-cycle pulse when an instruction completes
instret_count  output  CNT_W  retired-instruction count
trap  output  1  sticky; core halted
trap_cause  output  2  00 = none, 01 = illegal opcode, 10 = memory timeout

Behaviour:
- Reset:
  - State = FETCH; wait counter = 0; instret_count = 0; trap = 0; trap_cause = 00.
  - Outputs are decoded from state and op only, so in FETCH after reset: mem_req = 1, all write strobes = 0.
  - rst mid-transfer or mid-instruction abandons the instruction with no retire.
- Handshake:
  - A transfer completes on a cycle with mem_req & mem_ready.
  - mem_req, mem_we and addr_sel are held stable until completion.
  - mem_ready while mem_req = 0 is ignored.
- Strobes: all unlisted strobes are 0 in every state. imm_sel is decoded from op in DECODE, EXEC, MEM and WB, and is 000 in FETCH and TRAP.
- FETCH:
  - mem_req = 1, addr_sel = 0, mem_we = 0.
  - On handshake: ir_write = 1, pc_write = 1, pc_src = 00; go to DECODE.
- DECODE:
  - Legal ops: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other op goes to TRAP with cause 01; no strobes asserted.
  - Legal op goes to EXEC.
- EXEC, per op:
  - R: A = 00, B = 00, alu_op = 10; go to WB.
  - I-ALU: A = 00, B = 01, alu_op = 10; go to WB.
  - LOAD/STORE: A = 00, B = 01, alu_op = 00; go to MEM.
  - BRANCH: A = 00, B = 00, alu_op = 01, pc_src = 10, pc_write = branch_taken, retire = 1; go to FETCH.
  - JAL: pc_write = 1, pc_src = 10; go to WB.
  - JALR: A = 00, B = 01, alu_op = 00, pc_write = 1, pc_src = 01; go to WB.
  - LUI: A = 10, B = 01. AUIPC: A = 01, B = 01. Both alu_op = 00; go to WB.
- MEM:
  - mem_req = 1, addr_sel = 1, mem_we = 1 for STORE only.
  - On handshake, LOAD: mdr_write = 1; go to WB.
  - On handshake, STORE: retire = 1; go to FETCH.
- WB:
  - reg_write = 1, retire = 1; go to FETCH.
  - result_src: 01 for LOAD, 10 for JAL/JALR, else 00.
- Latency with zero-wait memory (FETCH handshake in its first cycle):
  - BRANCH: 3 cycles.
  - STORE, R, I-ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- Timeout:
  - With TIMEOUT > 0, a counter counts consecutive cycles in FETCH or MEM without handshake.
  - The counter clears on handshake and on entering FETCH or MEM.
  - On the TIMEOUT-th non-handshake cycle, go to TRAP with cause 10.
  - A handshake in that same cycle wins (no trap).
- TRAP:
  - All strobes and mem_req = 0; trap = 1; cause held.
  - Only rst exits.
- instret_count increments on every retire and wraps to 0 past all-ones.

Test Plan:
- ADDI (op 0010011), mem_ready tied 1 → states FETCH, DECODE, EXEC, WB. reg_write = 1 in cycle 4 with result_src = 00, alu_src_b = 01, alu_op = 10. retire pulses once; instret_count = 1.
- LW with mem_ready low for 2 cycles in MEM → total 7 cycles. mdr_write = 1 only on the handshake cycle. WB result_src = 01.
- BEQ with branch_taken = 1, then = 0 → EXEC has pc_write = 1/pc_src = 10, then pc_write = 0. Both retire in 3 cycles; no WB state entered.
- op = 1111111 → TRAP after DECODE; trap = 1, trap_cause = 01. mem_req stays 0 for 20 cycles; instret_count is unchanged.
- TIMEOUT = 4, mem_ready held 0 in FETCH → trap asserted with cause 10 after exactly 4 wait cycles. Repeat with mem_ready = 1 on cycle 4 → no trap, DECODE entered.
- rst pulsed during a store's MEM wait → next cycle in FETCH with mem_we = 0 and instret_count = 0. CNT_W = 4 with 16 retires → count wraps to 0.
